// File: rtl/branch_predictor.sv
// Fetch-side gshare predictor: same-cycle next-PC prediction from a PHT and a direct-mapped BTB,
// trained by execute-stage resolutions, with speculative global history and mispredict recovery.
module branch_predictor #(
   parameter int N = 12,
   parameter int B = 6
) (
   input  logic          clk,
   input  logic          rst,
   output logic          ready,
   input  logic          f_req,
   input  logic [31:0]   f_pc,
   output logic          f_pred_taken,
   output logic [31:0]   f_pred_pc,
   output logic [N-1:0]  f_pred_history,
   input  logic          e_upd_valid,
   input  logic [31:0]   e_upd_pc,
   input  logic          e_upd_is_cond,
   input  logic          e_upd_taken,
   input  logic [31:0]   e_upd_target,
   input  logic [N-1:0]  e_upd_history,
   input  logic          e_upd_mispredict
);
   localparam int TW = 30 - B;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e          state_q;
   logic [N-1:0]    idx_q;
   logic [N-1:0]    ghr_q, ghr_d;

   logic [1:0]      pht_q       [2**N];
   logic            btb_valid_q [2**B];
   logic [TW-1:0]   btb_tag_q   [2**B];
   logic [31:0]     btb_tgt_q   [2**B];
   logic            btb_cond_q  [2**B];

   logic            run;
   logic [N-1:0]    f_pidx, u_pidx;
   logic [B-1:0]    f_bidx, u_bidx;
   logic            f_hit, f_cond;
   logic            upd_en;
   logic [1:0]      u_ctr, u_ctr_d;
   logic            unused_pc_bits;

   assign run   = (state_q == ST_RUN);
   assign ready = run;

   // Lookup path: purely combinational from f_pc and registered tables, no write bypass.
   assign f_pidx         = f_pc[N+1:2] ^ ghr_q;
   assign f_bidx         = f_pc[B+1:2];
   assign f_hit          = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_pc[31:B+2]);
   assign f_cond         = btb_cond_q[f_bidx];
   assign f_pred_taken   = run && f_hit && (!f_cond || pht_q[f_pidx][1]);
   assign f_pred_pc      = f_pred_taken ? btb_tgt_q[f_bidx] : f_pc + 32'd4;
   assign f_pred_history = ghr_q;

   assign upd_en = run && e_upd_valid;
   assign u_pidx = e_upd_pc[N+1:2] ^ e_upd_history;
   assign u_bidx = e_upd_pc[B+1:2];
   assign u_ctr  = pht_q[u_pidx];

   assign unused_pc_bits = ^{f_pc[1:0], e_upd_pc[1:0]};

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      u_ctr_d = u_ctr;
      if (e_upd_taken && (u_ctr != 2'b11))
         u_ctr_d = u_ctr + 2'd1;
      else if (!e_upd_taken && (u_ctr != 2'b00))
         u_ctr_d = u_ctr - 2'd1;

      // A mispredict restore takes priority over the same-cycle speculative shift.
      ghr_d = ghr_q;
      if (upd_en && e_upd_mispredict)
         ghr_d = e_upd_is_cond ? {e_upd_history[N-2:0], e_upd_taken} : e_upd_history;
      else if (run && f_req && f_hit && f_cond)
         ghr_d = {ghr_q[N-2:0], f_pred_taken};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
         ghr_q   <= '0;
      end else begin
         ghr_q <= ghr_d;
         if (state_q == ST_INIT) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == '1)
               state_q <= ST_RUN;
         end
      end
   end

   // NOTE: table storage has no reset; the INIT sweep establishes counters and BTB valid bits.
   always_ff @(posedge clk) begin
      if (!run) begin
         pht_q[idx_q]              <= 2'b01;
         btb_valid_q[idx_q[B-1:0]] <= 1'b0;
      end else if (upd_en) begin
         if (e_upd_is_cond)
            pht_q[u_pidx] <= u_ctr_d;
         if (e_upd_taken) begin
            btb_valid_q[u_bidx] <= 1'b1;
            btb_tag_q[u_bidx]   <= e_upd_pc[31:B+2];
            btb_tgt_q[u_bidx]   <= e_upd_target;
            btb_cond_q[u_bidx]  <= e_upd_is_cond;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver pushes expected lookups into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;
   localparam int N      = 12;
   localparam int B      = 6;
   localparam int PHT_SZ = 1 << N;
   localparam int BTB_SZ = 1 << B;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic          f_req;
   logic [31:0]   f_pc;
   logic          f_pred_taken;
   logic [31:0]   f_pred_pc;
   logic [N-1:0]  f_pred_history;
   logic          e_upd_valid;
   logic [31:0]   e_upd_pc;
   logic          e_upd_is_cond;
   logic          e_upd_taken;
   logic [31:0]   e_upd_target;
   logic [N-1:0]  e_upd_history;
   logic          e_upd_mispredict;

   always #5 clk = ~clk;

   branch_predictor #(.N(N), .B(B)) dut (
      .clk              (clk),
      .rst              (rst),
      .ready            (ready),
      .f_req            (f_req),
      .f_pc             (f_pc),
      .f_pred_taken     (f_pred_taken),
      .f_pred_pc        (f_pred_pc),
      .f_pred_history   (f_pred_history),
      .e_upd_valid      (e_upd_valid),
      .e_upd_pc         (e_upd_pc),
      .e_upd_is_cond    (e_upd_is_cond),
      .e_upd_taken      (e_upd_taken),
      .e_upd_target     (e_upd_target),
      .e_upd_history    (e_upd_history),
      .e_upd_mispredict (e_upd_mispredict)
   );

   typedef struct {
      logic          rdy;
      logic          taken;
      logic [31:0]   pc;
      logic [N-1:0]  hist;
      int            id;
   } exp_t;

   exp_t  exp_q[$];
   exp_t  mon_e;
   exp_t  none_e;
   int    checks = 0;
   int    errors = 0;
   int    next_id = 0;
   bit    probe = 1'b0;

   // Reference model: plain integer tables indexed by the spec's address arithmetic.
   int            m_pht   [PHT_SZ];
   bit            m_bv    [BTB_SZ];
   int unsigned   m_btag  [BTB_SZ];
   logic [31:0]   m_btgt  [BTB_SZ];
   bit            m_bcond [BTB_SZ];
   logic [N-1:0]  m_ghr;
   int            m_init_left;

   function automatic int btb_slot(input logic [31:0] pc);
      return int'((pc >> 2) % BTB_SZ);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int bi;
      bi = btb_slot(pc);
      return m_bv[bi] && (m_btag[bi] == (pc >> (B + 2)));
   endfunction

   function automatic exp_t model_predict(input logic [31:0] pc);
      exp_t e;
      int   bi, pi;
      bi      = btb_slot(pc);
      pi      = int'((pc >> 2) % PHT_SZ) ^ int'(m_ghr);
      e.rdy   = (m_init_left == 0);
      e.taken = e.rdy && m_hit(pc) && (!m_bcond[bi] || (m_pht[pi] >= 2));
      e.pc    = e.taken ? m_btgt[bi] : pc + 32'd4;
      e.hist  = m_ghr;
      e.id    = 0;
      return e;
   endfunction

   // Advance the model across the coming clock edge using the inputs currently driven.
   task automatic model_step();
      exp_t          e;
      int            bi, pi;
      logic [N-1:0]  g;
      if (rst) begin
         for (int i = 0; i < PHT_SZ; i++) m_pht[i] = 1;
         for (int i = 0; i < BTB_SZ; i++) m_bv[i] = 1'b0;
         m_ghr       = '0;
         m_init_left = PHT_SZ;
         return;
      end
      if (m_init_left > 0) begin
         m_init_left--;
         return;
      end
      g = m_ghr;
      e = model_predict(f_pc);
      if (f_req && m_hit(f_pc) && m_bcond[btb_slot(f_pc)])
         g = N'((int'(m_ghr) << 1) | int'(e.taken));
      if (e_upd_valid) begin
         pi = int'((e_upd_pc >> 2) % PHT_SZ) ^ int'(e_upd_history);
         if (e_upd_is_cond) begin
            if (e_upd_taken) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
            else             m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
         end
         if (e_upd_taken) begin
            bi          = btb_slot(e_upd_pc);
            m_bv[bi]    = 1'b1;
            m_btag[bi]  = e_upd_pc >> (B + 2);
            m_btgt[bi]  = e_upd_target;
            m_bcond[bi] = e_upd_is_cond;
         end
         if (e_upd_mispredict)
            g = e_upd_is_cond ? N'((int'(e_upd_history) << 1) | int'(e_upd_taken)) : e_upd_history;
      end
      m_ghr = g;
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Monitor: compares the combinational prediction mid-cycle whenever the driver flagged a probe.
   always @(negedge clk) begin
      if (probe) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
         end else begin
            mon_e = exp_q.pop_front();
            check("ready",      mon_e.id, 32'(ready),          32'(mon_e.rdy));
            check("pred_taken", mon_e.id, 32'(f_pred_taken),   32'(mon_e.taken));
            check("pred_pc",    mon_e.id, f_pred_pc,           mon_e.pc);
            check("history",    mon_e.id, 32'(f_pred_history), 32'(mon_e.hist));
         end
      end
   end

   task automatic tick(input bit chk, input bit use_e, input exp_t ex);
      exp_t e;
      probe = chk;
      if (chk) begin
         if (use_e) e = ex;
         else       e = model_predict(f_pc);
         e.id = next_id;
         next_id++;
         exp_q.push_back(e);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, none_e);
   endtask

   task automatic step();
      tick(1'b1, 1'b0, none_e);
   endtask

   task automatic expect_c(input logic rdy, input logic taken, input logic [31:0] pc, input logic [N-1:0] hist);
      exp_t e;
      e.rdy   = rdy;
      e.taken = taken;
      e.pc    = pc;
      e.hist  = hist;
      e.id    = 0;
      tick(1'b1, 1'b1, e);
   endtask

   task automatic clear_upd();
      e_upd_valid      = 1'b0;
      e_upd_pc         = '0;
      e_upd_is_cond    = 1'b0;
      e_upd_taken      = 1'b0;
      e_upd_target     = '0;
      e_upd_history    = '0;
      e_upd_mispredict = 1'b0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic cond, input logic taken,
                          input logic [31:0] target, input logic [N-1:0] hist, input logic misp);
      e_upd_valid      = 1'b1;
      e_upd_pc         = pc;
      e_upd_is_cond    = cond;
      e_upd_taken      = taken;
      e_upd_target     = target;
      e_upd_history    = hist;
      e_upd_mispredict = misp;
   endtask

   // Few tags and small offsets so BTB aliasing and PHT reuse happen often.
   function automatic logic [31:0] rand_pc();
      logic [31:0] tag;
      tag = ($urandom_range(0, 7) == 0) ? ($urandom() >> 8) : 32'($urandom_range(0, 3));
      return (tag << (B + 2)) | (32'($urandom_range(0, BTB_SZ - 1)) << 2);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      f_req = 1'b0;
      f_pc  = 32'h1000;
      clear_upd();
      idle();
      idle();
      rst = 1'b0;

      // Init sweep: not ready for exactly 2^N cycles, lookups forced to fall through.
      for (int i = 0; i < PHT_SZ; i++) expect_c(1'b0, 1'b0, 32'h1004, '0);
      expect_c(1'b1, 1'b0, 32'h1004, '0);

      f_pc = 32'hFFFF_FFFC;
      expect_c(1'b1, 1'b0, 32'h0000_0000, '0);

      // Unconditional training.
      f_pc = 32'h1000;
      set_upd(32'h100, 1'b0, 1'b1, 32'h200, 12'h000, 1'b1);
      step();
      clear_upd();
      f_pc  = 32'h100;
      f_req = 1'b1;
      expect_c(1'b1, 1'b1, 32'h200, 12'h000);
      f_req = 1'b0;
      f_pc  = 32'h1000;
      expect_c(1'b1, 1'b0, 32'h1004, 12'h000);

      // Conditional saturation up, then speculative shift.
      set_upd(32'h40, 1'b1, 1'b1, 32'h80, 12'h000, 1'b0);
      step();
      step();
      clear_upd();
      f_pc  = 32'h40;
      f_req = 1'b1;
      expect_c(1'b1, 1'b1, 32'h80, 12'h000);
      f_req = 1'b0;
      f_pc  = 32'h1000;
      expect_c(1'b1, 1'b0, 32'h1004, 12'h001);

      // Saturation down with an extra not-taken, then history restores.
      set_upd(32'h40, 1'b1, 1'b0, 32'h80, 12'h000, 1'b0);
      for (int i = 0; i < 4; i++) step();
      set_upd(32'h300, 1'b0, 1'b0, 32'h0, 12'h000, 1'b1);
      step();
      clear_upd();
      f_pc = 32'h40;
      expect_c(1'b1, 1'b0, 32'h44, 12'h000);
      f_pc = 32'h1000;
      set_upd(32'h300, 1'b0, 1'b0, 32'h0, 12'h800, 1'b1);
      step();
      clear_upd();
      f_pc  = 32'h40;
      f_req = 1'b1;
      expect_c(1'b1, 1'b0, 32'h44, 12'h800);
      f_req = 1'b0;
      f_pc  = 32'h1000;
      expect_c(1'b1, 1'b0, 32'h1004, 12'h000);

      // Mispredict restore collides with a conditional-hit fetch shift.
      f_pc  = 32'h40;
      f_req = 1'b1;
      set_upd(32'h500, 1'b1, 1'b0, 32'h0, 12'hABC, 1'b1);
      expect_c(1'b1, 1'b0, 32'h44, 12'h000);
      clear_upd();
      f_req = 1'b0;
      f_pc  = 32'h1000;
      expect_c(1'b1, 1'b0, 32'h1004, 12'h578);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         f_req = 1'($urandom_range(0, 1));
         f_pc  = rand_pc();
         if ($urandom_range(0, 1) == 1)
            set_upd(rand_pc(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    $urandom() & 32'hFFFF_FFFC,
                    ($urandom_range(0, 1) == 1) ? m_ghr : N'($urandom()),
                    1'($urandom_range(0, 3) == 0));
         else
            clear_upd();
         step();
      end

      // Reset mid-run wipes training; updates during the re-sweep are ignored.
      f_req = 1'b0;
      set_upd(32'h100, 1'b0, 1'b1, 32'h200, 12'h000, 1'b1);
      f_pc = 32'h1000;
      step();
      clear_upd();
      f_pc = 32'h100;
      step();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      expect_c(1'b0, 1'b0, 32'h104, 12'h000);
      f_req = 1'b1;
      set_upd(32'h100, 1'b0, 1'b1, 32'h200, 12'h555, 1'b1);
      while (m_init_left > 0) step();
      clear_upd();
      f_req = 1'b0;
      expect_c(1'b1, 1'b0, 32'h104, 12'h000);
      idle();

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
